decrypt_seq: RTL and testbench
==============================

# decrypt_seq

Sequential, parametrised LWE decryption engine. It accepts a full ciphertext vector and secret key on a valid/ready handshake, then accumulates the inner product modulo q over several cycles, LANES products per cycle. It rounds the result to the nearest plaintext step and returns the plaintext together with the signed decryption noise. It sits between the ciphertext input buffer and the plaintext sink, and replaces the single-cycle combinational dot-product decryptor where DIMENSION is too large for one cycle.

## Interface
- PLAINTEXT_MODULUS, 64: p; must equal 2^PLAINTEXT_WIDTH.
- PLAINTEXT_WIDTH, 6: plaintext bits.
- DIMENSION, 16: LWE dimension; vectors carry DIMENSION+1 entries.
- CIPHERTEXT_MODULUS, 1024: q; must equal 2^CIPHERTEXT_WIDTH.
- CIPHERTEXT_WIDTH, 10: ciphertext/key element bits; must exceed PLAINTEXT_WIDTH by at least 1.
- LANES, 4: multiply-accumulate lanes per cycle, 1..DIMENSION+1.

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  cipher_text/secret_key are valid.
- in_ready  output  1  block can accept a new vector.
- secret_key  input  [CIPHERTEXT_WIDTH-1:0] x [DIMENSION:0]  unsigned key elements.
- cipher_text  input  signed [CIPHERTEXT_WIDTH-1:0] x [DIMENSION:0]  ciphertext elements.
- out_valid  output  1  result and noise are valid.
- out_ready  input  1  sink accepts the result.
- result  output  PLAINTEXT_WIDTH  decrypted plaintext.
- noise  output  signed CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH  accumulator minus result*Δ, with Δ = q/p.

## Operation
- Definitions: BEATS = ceil((DIMENSION+1)/LANES); Δ = 2^(CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH).
- FSM states: IDLE, ACC, FINAL, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, register both vectors, clear the accumulator and beat counter, then go to ACC.
  - ACC: each cycle, add the products for indices beat*LANES..beat*LANES+LANES-1 to the accumulator. Indices greater than DIMENSION contribute 0. After beat BEATS-1, go to FINAL.
  - FINAL: register result and noise, then go to DONE.
  - DONE: out_valid=1. result and noise are held stable until out_valid&&out_ready, then go to IDLE.
- in_ready=1 only in IDLE. Input vectors are captured, so inputs may change freely after acceptance.
- Arithmetic:
  - Each product is secret_key[i] (unsigned) times cipher_text[i] (signed, sign-extended); only the low CIPHERTEXT_WIDTH bits are kept.
  - The accumulator is CIPHERTEXT_WIDTH bits and wraps mod q.
- Rounding (round half up, mod p):
  - r = (acc + Δ/2) mod q.
  - result = r[CIPHERTEXT_WIDTH-1 : CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH].
  - noise = (acc - result*Δ) mod q, interpreted as a signed value in [-Δ/2, Δ/2-1]. It equals the low CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH bits of acc - result*Δ.
- Wrap-around: an accumulator value within Δ/2 below q rounds to result 0 with negative noise.
- in_valid asserted while the block is busy is ignored, and the sink stalls the block indefinitely. No input is lost, because in_ready=0 outside IDLE.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, result=0, noise=0.
  - Accumulator and beat counter are 0.
- Reset mid-operation aborts the vector in flight; no output is produced for it.
- Latency: the accept edge is edge 0. ACC updates occur on edges 1..BEATS. result, noise and out_valid become visible after edge BEATS+1 (6 with defaults).
- Throughput: one vector per BEATS+3 cycles when out_ready=1. in_ready returns 1 the cycle after the out handshake.
- out_valid, result and noise are registered; in_ready is decoded from state.

## Test plan
- Defaults; key[0]=1, all other key elements 0; ct[0]=80 -> after 6 cycles out_valid=1, result=5, noise=0.
- Same key; ct[0]=87 -> result=5, noise=+7. ct[0]=88 -> result=6, noise=-8 (round half up boundary).
- Same key; ct[0]=-4 -> accumulator 1020, result=0, noise=-4 (mod-q wrap-around and mod-p result wrap).
- All 17 key elements = 1, all ct = 5 -> acc=85, result=5, noise=+5. Repeat with LANES=1 (out after 18 cycles) and LANES=17 (out after 2 cycles); results must be identical.
- Hold out_ready=0 for 10 cycles while in_valid stays 1 with new data -> result stays stable, in_ready=0, second vector accepted only after the out handshake.
- Assert rst_n=0 in the third ACC cycle -> out_valid=0 immediately and in_ready=1 after release. The next vector decrypts correctly, with no residue from the aborted vector's accumulator.

Source files
------------

// File: rtl/decrypt_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : decrypt_seq_if
// Purpose  : Ciphertext-in / plaintext-out handshake bundle for decrypt_seq.
// Revision : 1.0
// ============================================================================
interface decrypt_seq_if #(
    parameter int DIMENSION        = 16,
    parameter int CIPHERTEXT_WIDTH = 10,
    parameter int PLAINTEXT_WIDTH  = 6
);
    logic                                           in_valid;
    logic                                           in_ready;
    logic        [CIPHERTEXT_WIDTH-1:0]             secret_key  [DIMENSION:0];
    logic signed [CIPHERTEXT_WIDTH-1:0]             cipher_text [DIMENSION:0];
    logic                                           out_valid;
    logic                                           out_ready;
    logic        [PLAINTEXT_WIDTH-1:0]              result;
    logic signed [CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH-1:0] noise;

    modport master (
        output in_valid, secret_key, cipher_text, out_ready,
        input  in_ready, out_valid, result, noise
    );

    modport slave (
        input  in_valid, secret_key, cipher_text, out_ready,
        output in_ready, out_valid, result, noise
    );
endinterface
`default_nettype wire

// File: rtl/decrypt_seq.sv
`default_nettype none
// ============================================================================
// Module   : decrypt_seq
// Purpose  : Multi-cycle LWE decryptor: LANES MACs per beat, round to plaintext.
// Revision : 1.0
// ============================================================================
module decrypt_seq #(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int DIMENSION          = 16,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 10,
    parameter int LANES              = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    decrypt_seq_if.slave bus
);
    localparam int NUM_ELEM = DIMENSION + 1;
    localparam int BEATS    = (NUM_ELEM + LANES - 1) / LANES;
    localparam int PAD      = BEATS * LANES;
    localparam int IDX_W    = (PAD > 1) ? $clog2(PAD) : 1;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NOISE_W  = CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH;
    localparam logic [CIPHERTEXT_WIDTH-1:0] HALF_DELTA =
        CIPHERTEXT_WIDTH'(CIPHERTEXT_MODULUS / PLAINTEXT_MODULUS / 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [CIPHERTEXT_WIDTH-1:0] key_q [PAD];
    logic [CIPHERTEXT_WIDTH-1:0] key_d [PAD];
    logic [CIPHERTEXT_WIDTH-1:0] ct_q  [PAD];
    logic [CIPHERTEXT_WIDTH-1:0] ct_d  [PAD];
    logic [CIPHERTEXT_WIDTH-1:0] acc_q, acc_d;
    logic [BEAT_W-1:0]           beat_q, beat_d;
    logic [PLAINTEXT_WIDTH-1:0]  result_q, result_d;
    logic [NOISE_W-1:0]          noise_q, noise_d;
    logic                        out_valid_q, out_valid_d;

    logic [CIPHERTEXT_WIDTH-1:0] key_in    [PAD];
    logic [CIPHERTEXT_WIDTH-1:0] ct_in     [PAD];
    logic [CIPHERTEXT_WIDTH-1:0] lane_prod [LANES];
    logic [CIPHERTEXT_WIDTH-1:0] lane_sum;
    logic [PLAINTEXT_WIDTH-1:0]  rnd_result;
    logic [NOISE_W-1:0]          rnd_noise;

    // Zero-padding the tail makes every lane of the last beat index in range.
    for (genvar i = 0; i < PAD; i++) begin : g_pad
        if (i < NUM_ELEM) begin : g_elem
            assign key_in[i] = bus.secret_key[i];
            assign ct_in[i]  = bus.cipher_text[i];
        end else begin : g_zero
            assign key_in[i] = '0;
            assign ct_in[i]  = '0;
        end
    end

    // Low bits of a product do not depend on signedness, so an unsigned
    // CIPHERTEXT_WIDTH multiply already gives the sign-extended product mod q.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IDX_W-1:0] idx;
        assign idx          = IDX_W'(int'(beat_q) * LANES + l);
        assign lane_prod[l] = key_q[idx] * ct_q[idx];
    end

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + lane_prod[l];
        end
    end

    // result*delta has all-zero low bits, so the noise is just acc's low bits.
    assign rnd_result = PLAINTEXT_WIDTH'((acc_q + HALF_DELTA) >> NOISE_W);
    assign rnd_noise  = acc_q[NOISE_W-1:0];

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        ct_d        = ct_q;
        acc_d       = acc_q;
        beat_d      = beat_q;
        result_d    = result_q;
        noise_d     = noise_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    key_d   = key_in;
                    ct_d    = ct_in;
                    acc_d   = '0;
                    beat_d  = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_d = acc_q + lane_sum;
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    beat_d  = '0;
                    state_d = S_FINAL;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            S_FINAL: begin
                result_d    = rnd_result;
                noise_d     = rnd_noise;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            key_q       <= '{default: '0};
            ct_q        <= '{default: '0};
            acc_q       <= '0;
            beat_q      <= '0;
            result_q    <= '0;
            noise_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            ct_q        <= ct_d;
            acc_q       <= acc_d;
            beat_q      <= beat_d;
            result_q    <= result_d;
            noise_q     <= noise_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.noise     = noise_q;
endmodule
`default_nettype wire

// File: tb/tb_decrypt_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_decrypt_seq
// Purpose  : Directed checks of decrypt_seq with LANES = 4, 1 and 17.
// Revision : 1.0
// ============================================================================
module tb_decrypt_seq;
    localparam int DIM = 16;
    localparam int CW  = 10;
    localparam int PW  = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    decrypt_seq_if #(.DIMENSION(DIM), .CIPHERTEXT_WIDTH(CW), .PLAINTEXT_WIDTH(PW))
        b4 (), b1 (), b17 ();

    decrypt_seq #(.LANES(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    decrypt_seq #(.LANES(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    decrypt_seq #(.LANES(17)) u_dut17 (.clk(clk), .rst_n(rst_n), .bus(b17.slave));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // key[0]=k0, other keys=k_all; ct[0]=c0, other cts=c_all; same data on all buses
    task automatic load(input int k_all, input int k0, input int c_all, input int c0);
        for (int i = 0; i <= DIM; i++) begin
            b4.secret_key[i]   = CW'((i == 0) ? k0 : k_all);
            b1.secret_key[i]   = CW'((i == 0) ? k0 : k_all);
            b17.secret_key[i]  = CW'((i == 0) ? k0 : k_all);
            b4.cipher_text[i]  = CW'((i == 0) ? c0 : c_all);
            b1.cipher_text[i]  = CW'((i == 0) ? c0 : c_all);
            b17.cipher_text[i] = CW'((i == 0) ? c0 : c_all);
        end
    endtask

    task automatic accept4(input string tag);
        int n = 0;
        b4.in_valid = 1'b1;
        while (!b4.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_in_ready"}, int'(b4.in_ready), 1);
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
    endtask

    task automatic wait_out4(input string tag, input int lat);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!b4.out_valid && n < 40);
        chk({tag, "_latency"}, n, lat);
    endtask

    task automatic handshake4(input string tag);
        b4.out_ready = 1'b1;
        @(posedge clk); #1;
        b4.out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, int'(b4.out_valid), 0);
        chk({tag, "_in_ready_back"}, int'(b4.in_ready), 1);
    endtask

    task automatic decrypt4(input string tag, input int c0, input int exp_res, input int exp_noise);
        load(0, 1, 0, c0);
        accept4(tag);
        wait_out4(tag, 6);
        chk({tag, "_result"}, int'(b4.result), exp_res);
        chk({tag, "_noise"}, int'(b4.noise), exp_noise);
        handshake4(tag);
    endtask

    initial begin
        int l4, l1, l17;
        b4.in_valid  = 1'b0; b1.in_valid  = 1'b0; b17.in_valid  = 1'b0;
        b4.out_ready = 1'b0; b1.out_ready = 1'b0; b17.out_ready = 1'b0;
        load(0, 0, 0, 0);

        #12;
        chk("rst_in_ready", int'(b4.in_ready), 1);
        chk("rst_out_valid", int'(b4.out_valid), 0);
        chk("rst_result", int'(b4.result), 0);
        chk("rst_noise", int'(b4.noise), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        decrypt4("ct80", 80, 5, 0);
        decrypt4("ct87", 87, 5, 7);
        decrypt4("ct88", 88, 6, -8);
        decrypt4("ctm4", -4, 0, -4);

        // Same all-ones vector into the three lane configurations at once
        load(1, 1, 5, 5);
        b4.in_valid = 1'b1; b1.in_valid = 1'b1; b17.in_valid = 1'b1;
        @(posedge clk); #1;
        b4.in_valid = 1'b0; b1.in_valid = 1'b0; b17.in_valid = 1'b0;
        l4 = 0; l1 = 0; l17 = 0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            if (b4.out_valid  && l4  == 0) l4  = c;
            if (b1.out_valid  && l1  == 0) l1  = c;
            if (b17.out_valid && l17 == 0) l17 = c;
        end
        chk("lanes4_latency", l4, 6);
        chk("lanes1_latency", l1, 18);
        chk("lanes17_latency", l17, 2);
        chk("lanes4_result", int'(b4.result), 5);
        chk("lanes4_noise", int'(b4.noise), 5);
        chk("lanes1_result", int'(b1.result), 5);
        chk("lanes1_noise", int'(b1.noise), 5);
        chk("lanes17_result", int'(b17.result), 5);
        chk("lanes17_noise", int'(b17.noise), 5);
        b4.out_ready = 1'b1; b1.out_ready = 1'b1; b17.out_ready = 1'b1;
        @(posedge clk); #1;
        b4.out_ready = 1'b0; b1.out_ready = 1'b0; b17.out_ready = 1'b0;
        chk("lanes_all_idle", int'(b4.in_ready & b1.in_ready & b17.in_ready), 1);

        // Sink stall with a second vector pending on the input
        load(0, 1, 0, 80);
        accept4("stallA");
        wait_out4("stallA", 6);
        load(0, 1, 0, 88);
        b4.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("stall_result", int'(b4.result), 5);
            chk("stall_in_ready", int'(b4.in_ready), 0);
        end
        b4.out_ready = 1'b1;
        @(posedge clk); #1;
        b4.out_ready = 1'b0;
        chk("stall_release_out_valid", int'(b4.out_valid), 0);
        chk("stall_release_in_ready", int'(b4.in_ready), 1);
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
        chk("stallB_accepted", int'(b4.in_ready), 0);
        wait_out4("stallB", 6);
        chk("stallB_result", int'(b4.result), 6);
        chk("stallB_noise", int'(b4.noise), -8);
        handshake4("stallB");

        // Asynchronous reset during the third accumulation cycle
        load(1, 1, 5, 5);
        accept4("abort");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(b4.out_valid), 0);
        chk("abort_in_ready", int'(b4.in_ready), 1);
        @(negedge clk); rst_n = 1'b1;
        l4 = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (b4.out_valid) l4++;
        end
        chk("abort_no_output", l4, 0);
        decrypt4("after_abort", 80, 5, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
